reaction_timer: RTL

//  Responder side of the start-light sequence: measures player reaction time in ms from

---
 rtl/reaction_timer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer
// Brief    : Measures lights-out to debounced key press time in BCD ms and
//            flags false starts and full-scale overflow.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer #(
    parameter int N_DIGITS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_ms,
    input  logic                  arm,
    input  logic                  lights_out,
    input  logic                  key_n,
    output logic [4*N_DIGITS-1:0] react_bcd,
    output logic                  valid,
    output logic                  false_start,
    output logic                  overflow,
    output logic                  busy
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3,
        ST_FOUL   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_synced;
    logic                    r_db_level;
    logic [c_cnt_w-1:0]      r_db_cnt;
    logic                    r_press;
    logic [4*N_DIGITS-1:0]   r_react;
    logic [4*N_DIGITS-1:0]   w_bcd_inc;
    logic [4*N_DIGITS-1:0]   w_full_scale;
    logic [N_DIGITS-1:0]     w_carry;
    logic                    w_count;
    logic                    w_inc_full;
    logic                    r_valid;
    logic                    r_false_start;
    logic                    r_overflow;
    logic                    r_busy;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= key_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // A new level must disagree on DEBOUNCE_TICKS consecutive ticks; any
    // agreement in between restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_press    <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_synced == r_db_level) begin
                r_db_cnt <= '0;
            end else if (tick_ms) begin
                if (r_db_cnt == c_db_last) begin
                    r_db_level <= w_synced;
                    r_db_cnt   <= '0;
                    r_press    <= ~w_synced;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end
    end

    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
            logic [3:0] w_d;
            assign w_d                    = r_react[4*i +: 4];
            assign w_full_scale[4*i +: 4] = 4'd9;
            assign w_bcd_inc[4*i +: 4]    = !w_carry[i] ? w_d :
                                            (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
            if (i < N_DIGITS - 1) begin : g_carry
                assign w_carry[i+1] = w_carry[i] & (w_d == 4'd9);
            end
        end
    endgenerate

    // A tick coinciding with the press is not part of the reaction time.
    assign w_count    = (r_state == ST_TIMING) && tick_ms && !r_press;
    assign w_inc_full = (w_bcd_inc == w_full_scale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (r_press) begin
                        w_state_next = ST_FOUL;
                    end else if (lights_out) begin
                        w_state_next = ST_TIMING;
                    end
                end
                ST_TIMING: begin
                    if (r_press || (w_count && w_inc_full)) begin
                        w_state_next = ST_DONE;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_react       <= '0;
            r_valid       <= 1'b0;
            r_false_start <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (arm) begin
                r_react    <= '0;
                r_overflow <= 1'b0;
            end else if (w_count) begin
                r_react <= w_bcd_inc;
                if (w_inc_full) begin
                    r_overflow <= 1'b1;
                end
            end
            r_valid       <= (w_state_next == ST_DONE);
            r_false_start <= (w_state_next == ST_FOUL);
            r_busy        <= (w_state_next == ST_ARMED) || (w_state_next == ST_TIMING);
        end
    end

    assign react_bcd   = r_react;
    assign valid       = r_valid;
    assign false_start = r_false_start;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule
`default_nettype wire
